// File: rtl/systolic_array_collector.sv
// systolic_array_collector
//   Drain stage for the no-stall shift-add PE chain. Each accepted inject
//   is tagged, the tag is delayed by the chain latency, and the matching
//   y_in result is captured into a small FIFO presented on a val/rdy port.
//   Credits (inject_ok) keep stored + in-flight results within the FIFO depth.
//
// Parameters:
//   data_width : width of y results
//   p_latency  : cycles from accepted inject to matching y_in (>= 1)
//   p_depth    : FIFO entries (power of two, >= 2)
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset
//   inject_val in   feeder pushed a sample into the PE chain this cycle
//   inject_ok  out  feeder may inject this cycle
//   y_in       in   y_out of the last PE
//   out_msg    out  FIFO head (0 while empty)
//   out_val    out  FIFO non-empty
//   out_rdy    in   consumer accepts out_msg
//   err        out  sticky protocol-violation flag (only with
//                   SYSTOLIC_COLLECTOR_ERR_EN defined)
//
// Build option: define SYSTOLIC_COLLECTOR_ERR_EN to add the err port.

module systolic_array_collector #(
    parameter int data_width = 32,
    parameter int p_latency  = 4,
    parameter int p_depth    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inject_val,
    output logic                  inject_ok,
    input  logic [data_width-1:0] y_in,
    output logic [data_width-1:0] out_msg,
    output logic                  out_val,
    input  logic                  out_rdy
`ifdef SYSTOLIC_COLLECTOR_ERR_EN
    ,
    output logic                  err
`endif
);

    localparam int AW = $clog2(p_depth);
    localparam int CW = AW + 1;
    localparam logic [CW:0]   DEPTH_SUM = (CW+1)'(p_depth);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(p_depth);

    logic [p_latency-1:0]  tag_q, tag_d;
    logic [AW-1:0]         head_q, head_d;
    logic [AW-1:0]         tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         in_flight_q, in_flight_d;
    logic [data_width-1:0] mem_q [p_depth];

    logic accept;
    logic push;
    logic pop;
    logic [CW:0] credit_sum;

    // Credit check uses registered state only, so out_rdy / inject_val
    // never reach inject_ok combinationally.
    assign credit_sum = {1'b0, count_q} + {1'b0, in_flight_q};
    assign inject_ok  = !reset && (credit_sum < DEPTH_SUM);

    assign accept  = inject_val && inject_ok;
    assign push    = tag_q[p_latency-1];
    assign out_val = (count_q != '0);
    assign pop     = out_val && out_rdy;
    assign out_msg = out_val ? mem_q[head_q] : '0;

    always_comb begin
        tag_d    = '0;
        tag_d[0] = accept;
        for (int unsigned i = 1; i < p_latency; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        head_d = head_q;
        tail_d = tail_q;
        if (pop)  head_d = head_q + 1'b1;   // pointers wrap: p_depth is 2^AW
        if (push) tail_d = tail_q + 1'b1;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        in_flight_d = in_flight_q;
        case ({accept, push})
            2'b10:   in_flight_d = in_flight_q + 1'b1;
            2'b01:   in_flight_d = in_flight_q - 1'b1;
            default: in_flight_d = in_flight_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q       <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            in_flight_q <= '0;
        end else begin
            tag_q       <= tag_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            in_flight_q <= in_flight_d;
        end
    end

    // Storage is not reset; out_msg is gated while empty.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[tail_q] <= y_in;
        end
    end

`ifdef SYSTOLIC_COLLECTOR_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (inject_val && !inject_ok)       err_d = 1'b1;
        if (push && (count_q == DEPTH_CNT)) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign err = err_q;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        $display("[collector] count=%0d in_flight=%0d out_val=%0b out_msg=%h",
                 count_q, in_flight_q, out_val, out_msg);
    end
`endif

endmodule

// File: tb/tb_systolic_array_collector.sv
module tb_systolic_array_collector;

    localparam int W   = 32;
    localparam int LAT = 4;
    localparam int D   = 4;

    logic         clk;
    logic         reset;
    logic         inject_val;
    logic         inject_ok;
    logic [W-1:0] y_in;
    logic [W-1:0] out_msg;
    logic         out_val;
    logic         out_rdy;
`ifdef SYSTOLIC_COLLECTOR_ERR_EN
    logic         err;
`endif

    systolic_array_collector #(
        .data_width(W),
        .p_latency (LAT),
        .p_depth   (D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .inject_val(inject_val),
        .inject_ok (inject_ok),
        .y_in      (y_in),
        .out_msg   (out_msg),
        .out_val   (out_val),
        .out_rdy   (out_rdy)
`ifdef SYSTOLIC_COLLECTOR_ERR_EN
        ,
        .err       (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle c = interval after the c-th posedge; its inputs are sampled at posedge c+1.
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] val;
        int           acc_cyc;
    } exp_t;

    typedef struct {
        int           due;
        logic [W-1:0] val;
    } pend_t;

    // Every accepted, not yet consumed result, in acceptance order.
    exp_t  exp_q[$];
    // Results the PE chain still has to present on y_in.
    pend_t pend_q[$];

    bit ok_model  = 1'b0;
    bit err_model = 1'b0;
    bit err_nxt   = 1'b0;
    bit dead_mode = 1'b0;

    int tests = 0;
    int fails = 0;

    function automatic bit model_ok();
        return exp_q.size() < D;
    endfunction

    task automatic drive(input bit r, input bit iv, input logic [W-1:0] v, input bit rdy);
        bit ok;
        ok = !r && model_ok();
        ok_model   = ok;
        reset      = r;
        inject_val = iv;
        out_rdy    = rdy && !r;
        if (r) begin
            exp_q.delete();
            pend_q.delete();
        end
        if (!r && pend_q.size() > 0 && pend_q[0].due == cyc) begin
            y_in = pend_q[0].val;
            void'(pend_q.pop_front());
        end else begin
            y_in = dead_mode ? 32'h0000_DEAD : W'($urandom);
        end
        if (iv && ok) begin
            exp_q.push_back('{val: v, acc_cyc: cyc});
            pend_q.push_back('{due: cyc + LAT, val: v});
        end
        err_nxt = r ? 1'b0 : (err_model | (iv & !ok));
        @(posedge clk);
        #2;
        err_model = err_nxt;
    endtask

    // Monitor: compares DUT outputs against the model mid-cycle and pops on handshake.
    initial begin
        forever begin
            @(negedge clk);
            tests++;
            if (inject_ok !== ok_model) begin
                fails++;
                $display("FAIL inject_ok cyc=%0d got=%b exp=%b", cyc, inject_ok, ok_model);
            end
`ifdef SYSTOLIC_COLLECTOR_ERR_EN
            tests++;
            if (err !== err_model) begin
                fails++;
                $display("FAIL err cyc=%0d got=%b exp=%b", cyc, err, err_model);
            end
`endif
            if (!reset) begin
                bit           ev;
                logic [W-1:0] em;
                ev = (exp_q.size() > 0) && (exp_q[0].acc_cyc + LAT < cyc);
                em = ev ? exp_q[0].val : '0;
                tests++;
                if (out_val !== ev) begin
                    fails++;
                    $display("FAIL out_val cyc=%0d got=%b exp=%b", cyc, out_val, ev);
                end
                tests++;
                if (out_msg !== em) begin
                    fails++;
                    $display("FAIL out_msg cyc=%0d got=%h exp=%h", cyc, out_msg, em);
                end
                if (ev && out_rdy) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int n;
        reset = 1'b1; inject_val = 1'b0; out_rdy = 1'b0; y_in = '0;

        repeat (3) drive(1, 0, '0, 0);

        // Single sample
        drive(0, 1, 32'h0000_0055, 1);
        repeat (8) drive(0, 0, '0, 1);

        // Streaming: 12 results, credit-limited since D < LAT+1
        n = 0;
        for (int i = 0; i < 100 && n < 12; i++) begin
            if (model_ok()) begin
                drive(0, 1, 32'h100 + n, 1);
                n++;
            end else begin
                drive(0, 0, '0, 1);
            end
        end
        repeat (8) drive(0, 0, '0, 1);

        // Backpressure: 6 attempts, 4 accepted, extras ignored
        for (int i = 0; i < 6; i++) drive(0, 1, 32'hB0 + i, 0);
        repeat (6) drive(0, 0, '0, 0);
        repeat (8) drive(0, 0, '0, 1);

        // Push/pop at count=1 and pointer wrap
        n = 0;
        for (int i = 0; i < 100 && n < 8; i++) begin
            if (model_ok()) begin
                drive(0, 1, 32'hA0 + n, 1);
                n++;
            end else begin
                drive(0, 0, '0, 1);
            end
        end
        repeat (8) drive(0, 0, '0, 1);

        // Reset mid-flight; the stale tag cycles see 0xDEAD on y_in
        for (int i = 0; i < 3; i++) drive(0, 1, 32'hC0 + i, 1);
        dead_mode = 1'b1;
        drive(1, 0, '0, 0);
        repeat (8) drive(0, 0, '0, 1);
        dead_mode = 1'b0;

        // Randomised traffic including protocol violations
        for (int i = 0; i < 500; i++) begin
            drive(0, ($urandom % 4) != 0, W'($urandom), ($urandom % 3) != 0);
        end

        // Final drain, bounded
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            drive(0, 0, '0, 1);
            n++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end

        // Reset clears sticky state
        drive(1, 0, '0, 0);
        repeat (2) drive(0, 0, '0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/systolic_array_collector.md
Name: systolic_array_collector

Overview:
- Downstream drain stage for the shift-add systolic PE chain in the LK optical-flow datapath.
- The PE chain has no stall; it advances every cycle. This block tags each injected sample, delays the tag by the chain latency, and captures the matching y result from the last PE into a small FIFO.
- It presents results on a val/rdy output interface.
- It returns credits (inject_ok) to the upstream feeder, so the feeder never injects a sample the FIFO could not hold.

Parameters:
- data_width, 32, width of y results.
- p_latency, 4, cycles from an accepted inject to the matching result on y_in (≥1).
- p_depth, 4, FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- inject_val  in  1  feeder pushed a sample into PE chain this cycle.
- inject_ok  out  1  feeder may inject this cycle (credit available).
- y_in  in  data_width  y_out of last PE in chain.
- out_msg  out  data_width  FIFO head result.
- out_val  out  1  FIFO non-empty.
- out_rdy  in  1  consumer accepts out_msg.

Behaviour:
- Single clock domain. Synchronous, active-high reset.
- Reset clears:
  - tag delay line
  - FIFO pointers and count
  - in_flight counter
- Reset outputs:
  - out_val=0
  - out_msg=0 (storage is not cleared; out_msg is gated to 0 when empty)
  - inject_ok=0 while reset is high
- Accepted inject: inject_val & inject_ok.
  - inject_val while inject_ok=0 is ignored: no tag, no state change.
- Tag delay line:
  - p_latency-stage shift register of 1-bit tags; stage 0 loads the accepted-inject flag.
  - The tag exiting stage p_latency-1 at cycle t+p_latency marks y_in valid for an inject accepted at cycle t.
- Push: exiting tag=1 → y_in written at the tail in the same edge; tail advances.
  - y_in is sampled only when the tag is set. Other cycles are don't-care.
- Pop: out_val & out_rdy → head advances.
- out_msg: combinational read of the head entry. Valid only while out_val=1.
- in_flight (width clog2(p_depth)+1):
  - +1 on accepted inject
  - −1 on push
  - unchanged when both occur in the same cycle
- count (width clog2(p_depth)+1): +1 push, −1 pop, unchanged when both occur.
- inject_ok = !reset & (count + in_flight < p_depth), computed from registered state only.
  - No combinational path from out_rdy or inject_val to inject_ok.
  - A pop frees a credit visible the next cycle.
- Invariant: count + in_flight ≤ p_depth. A push therefore never finds the FIFO full.
- Push and pop in the same cycle are both performed; with count=1 the entry pops and the new entry becomes head next cycle.
- Pointers wrap modulo p_depth.
- Latency from inject to out_val rising (empty FIFO): p_latency+1 cycles.
- Throughput: 1 result/cycle when out_rdy is held high.
  - Credit loop: the feeder can sustain 1/cycle only if p_depth ≥ p_latency+1. Smaller depth limits rate; this is legal, not an error.
- Reset mid-operation: in-flight tags are dropped and later y_in values are ignored; FIFO contents are discarded. The upstream PE chain is reset by the same signal.
- No arithmetic on data; results are passed bit-exact.

Optional Feature:
- Macro SYSTOLIC_COLLECTOR_ERR_EN.
- Defined: adds output port err (1 bit), a sticky flag.
  - Set on inject_val=1 while inject_ok=0 (protocol violation).
  - Set on a push attempted while count==p_depth, which should be unreachable.
  - Cleared only by reset; reset value 0.
  - Behaviour of the other ports is unchanged: violating injects are still ignored.
- Undefined: no err port, no checking logic. Violating injects are silently ignored.
- Under `ifndef SYNTHESIS`, a line trace always prints count, in_flight and out_msg/out_val.

Test Plan:
- Single sample: reset, inject at cycle 0, y_in=0x0000_0055 at cycle 4 → out_val=1 at cycle 5, out_msg=0x55; pop with out_rdy=1 → out_val=0 at cycle 6.
- Streaming: inject every cycle for 12 cycles with out_rdy=1 and y_in=0x100+k at each tag → at most 4 inflight+stored; 12 results out in order 0x100..0x10B; inject_ok drops when credits are exhausted (p_depth=4 < p_latency+1=5) and no result is lost.
- Backpressure: out_rdy=0, inject 6 times → inject_ok=0 after 4 accepted; count reaches 4 at cycle 8; extra injects are ignored. Raise out_rdy → the 4 results drain in order, then inject_ok=1.
- Simultaneous push/pop at count=1 → count stays 1, order preserved, pointers wrap after 4 pushes (values 0xA0..0xA7 in order).
- Reset mid-flight: 3 accepted injects, assert reset at cycle 2 for one cycle, then drive y_in=0xDEAD on the former tag cycles → out_val stays 0 and inject_ok=1 after reset deasserts.
- ERR_EN build: inject_val=1 while inject_ok=0 → err=1 next cycle and stays 1 until reset; non-ERR build → same stimulus, outputs identical except no err port.
